x_sram_arb: RTL and testbench
=============================

X_SRAM_ARB -- requirements
Module: x_sram_arb

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning i_clk cycles per o_mem_advance pulse (legal range 1..255).
REQ-002 SHALL have port i_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have, for N in {0,1}, port i_pN_valid  in  1  requester N request valid.
REQ-005 SHALL have, for N in {0,1}, port o_pN_accept  out  1  single-cycle pulse: request N consumed.
REQ-006 SHALL have, for N in {0,1}, port i_pN_rd_n_wr  in  1  request type: 1=read, 0=write.
REQ-007 SHALL have, for N in {0,1}, port i_pN_addr  in  16  byte address.
REQ-008 SHALL have, for N in {0,1}, port i_pN_wdata  in  8  write data.
REQ-009 SHALL have, for N in {0,1}, port o_pN_ready  out  1  single-cycle read-completion pulse.
REQ-010 SHALL have, for N in {0,1}, port o_pN_rdata  out  8  read data, qualified by o_pN_ready.
REQ-011 SHALL have port o_mem_advance  out  1  bit-tick to the SPI SRAM controller.
REQ-012 SHALL have port o_mem_valid  out  1  request valid to the controller.
REQ-013 SHALL have port i_mem_accept  in  1  controller accept pulse.
REQ-014 SHALL have ports o_mem_rd_n_wr, o_mem_addr and o_mem_wdata  out  1/16/8  muxed request fields.
REQ-015 SHALL have ports i_mem_ready and i_mem_rdata  in  1/8  controller read completion.

Function
REQ-016 Tick: counter 0..DIV-1, increments every cycle, wraps to 0; o_mem_advance=1 exactly when counter==DIV-1; DIV=1 gives o_mem_advance high every cycle.
REQ-017 FSM states: IDLE, GRANT, WAIT_RD.
REQ-018 IDLE: with no valid, stay in IDLE; with any i_pN_valid, latch owner and go to GRANT the next cycle.
REQ-019 Arbitration: one valid wins; with both valid, the port not equal to last_grant wins; last_grant updates to owner on entry to GRANT.
REQ-020 GRANT: o_mem_valid, o_mem_rd_n_wr, o_mem_addr, o_mem_wdata = owner's inputs combinationally; other port ignored.
REQ-021 GRANT: o_p{owner}_accept = i_mem_accept; on accept, read -> WAIT_RD, write -> IDLE.
REQ-022 WAIT_RD: o_mem_valid=0 (no sequential-burst hop), o_p{owner}_ready=i_mem_ready, o_p{owner}_rdata=i_mem_rdata; on i_mem_ready -> IDLE.
REQ-023 Non-owner o_pN_accept, o_pN_ready = 0 and o_pN_rdata = 0 at all times; outside GRANT, o_mem_* request outputs = 0.
REQ-024 Requester SHALL hold valid and fields stable from assertion to accept, because the controller shifts the address live; the arbiter holds the grant and does not check for drops.
REQ-025 Grant is locked: GRANT leaves only on i_mem_accept, and WAIT_RD leaves only on i_mem_ready; no timeout.
REQ-026 Ready and a new request in the same cycle: the transition to IDLE takes priority; arbitration occurs the following cycle (minimum 1 IDLE cycle between grants).
REQ-027 Back-to-back with both ports continuously valid: grants strictly alternate 0,1,0,1...

Reset
REQ-028 On i_rst: state=IDLE, tick counter=0, last_grant=1 (port 0 wins first contention), owner=0.
REQ-029 On i_rst, all outputs = 0, including o_mem_advance.
REQ-030 Reset mid-GRANT or mid-WAIT_RD abandons the transaction with no accept or ready pulse; the controller is reset by its own reset.

Structure
REQ-031 Package x_sram_pkg SHALL hold the state enum, the port-index type and the DIV default constant.
REQ-032 Sub-module x_sram_tick SHALL implement REQ-016; the arbiter FSM and request mux remain in x_sram_arb.

Verification
REQ-033 Bench scenario, single read: DIV=4, p0 reads 0x0123 with controller model returning 0xA5 -> one o_p0_accept pulse, then one o_p0_ready pulse with o_p0_rdata=0xA5; p1 outputs stay 0 throughout.
REQ-034 Bench scenario, contention after reset: p0 write 0x0010/0x3C and p1 read 0x0020 raised in the same cycle -> p0 granted first, p1 granted after the p0 accept; memory model holds 0x3C at 0x0010.
REQ-035 Bench scenario, fairness: both ports continuously valid for 8 transactions -> grant order 0,1,0,1,0,1,0,1.
REQ-036 Bench scenario, tick: DIV=3 -> o_mem_advance high on cycles 2,5,8 after reset release; DIV=1 -> high every cycle.
REQ-037 Bench scenario, reset mid-read: i_rst asserted in WAIT_RD -> next cycle state=IDLE, no o_pN_ready pulse, and a new p1 request is served normally.
REQ-038 Bench scenario, non-owner gating: i_mem_ready asserted while p1 owns a read -> o_p0_ready=0 and o_p0_rdata=0x00.

Source files
------------

// File: rtl/x_sram_pkg.sv
// Shared types and constants for the two-port SPI SRAM arbiter.
// Handshake: a requester holds valid and its fields steady until it sees its accept pulse.
package x_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_WAIT_RD = 2'd2
  } arb_state_e;

  typedef logic port_idx_t;

  localparam int unsigned DIV_DEFAULT = 4;

endpackage

// File: rtl/x_sram_tick.sv
// Free-running bit-tick divider: pulses once every DIV clock cycles.
// The pulse is forced low while reset is asserted.
module x_sram_tick
  import x_sram_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 8'd0;
    end else if (r_cnt == LAST) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_tick = (r_cnt == LAST) & ~i_rst;

endmodule

// File: rtl/x_sram_arb.sv
// Two-port arbiter in front of an SPI SRAM controller with locked grants and
// alternating priority on contention. o_dbg_state exposes the FSM state.
module x_sram_arb
  import x_sram_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_p0_valid,
  output logic        o_p0_accept,
  input  logic        i_p0_rd_n_wr,
  input  logic [15:0] i_p0_addr,
  input  logic [7:0]  i_p0_wdata,
  output logic        o_p0_ready,
  output logic [7:0]  o_p0_rdata,
  input  logic        i_p1_valid,
  output logic        o_p1_accept,
  input  logic        i_p1_rd_n_wr,
  input  logic [15:0] i_p1_addr,
  input  logic [7:0]  i_p1_wdata,
  output logic        o_p1_ready,
  output logic [7:0]  o_p1_rdata,
  output logic        o_mem_advance,
  output logic        o_mem_valid,
  input  logic        i_mem_accept,
  output logic        o_mem_rd_n_wr,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic [7:0]  i_mem_rdata,
  output logic [1:0]  o_dbg_state
);

  arb_state_e r_state;
  port_idx_t  r_owner;
  port_idx_t  r_last_grant;

  port_idx_t   w_winner;
  logic        w_any_valid;
  logic        w_own_valid;
  logic        w_own_rd;
  logic [15:0] w_own_addr;
  logic [7:0]  w_own_wdata;
  logic        w_in_grant;
  logic        w_in_wait;
  logic        w_acc;
  logic        w_rdy;

  x_sram_tick #(.DIV(DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (o_mem_advance)
  );

  // On contention the port that did not win last time gets the grant.
  assign w_any_valid = i_p0_valid | i_p1_valid;
  assign w_winner    = (i_p0_valid & i_p1_valid) ? ~r_last_grant :
                       (i_p0_valid ? 1'b0 : 1'b1);

  assign w_own_valid = r_owner ? i_p1_valid   : i_p0_valid;
  assign w_own_rd    = r_owner ? i_p1_rd_n_wr : i_p0_rd_n_wr;
  assign w_own_addr  = r_owner ? i_p1_addr    : i_p0_addr;
  assign w_own_wdata = r_owner ? i_p1_wdata   : i_p0_wdata;

  // Gating with ~i_rst keeps every output quiet in the reset cycle itself.
  assign w_in_grant = (r_state == ST_GRANT) & ~i_rst;
  assign w_in_wait  = (r_state == ST_WAIT_RD) & ~i_rst;
  assign w_acc      = w_in_grant & i_mem_accept;
  assign w_rdy      = w_in_wait & i_mem_ready;

  assign o_mem_valid   = w_in_grant & w_own_valid;
  assign o_mem_rd_n_wr = w_in_grant & w_own_rd;
  assign o_mem_addr    = w_in_grant ? w_own_addr : 16'd0;
  assign o_mem_wdata   = w_in_grant ? w_own_wdata : 8'd0;

  assign o_p0_accept = w_acc & ~r_owner;
  assign o_p1_accept = w_acc & r_owner;
  assign o_p0_ready  = w_rdy & ~r_owner;
  assign o_p1_ready  = w_rdy & r_owner;
  assign o_p0_rdata  = (w_in_wait & ~r_owner) ? i_mem_rdata : 8'd0;
  assign o_p1_rdata  = (w_in_wait & r_owner) ? i_mem_rdata : 8'd0;

  assign o_dbg_state = r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (i_mem_accept) begin
            r_state <= w_own_rd ? ST_WAIT_RD : ST_IDLE;
          end
        end
        ST_WAIT_RD: begin
          if (i_mem_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x_sram_arb.sv
// Directed bench for x_sram_arb: single read, contention, fairness, tick, reset mid-read.
// The bench plays both requesters and a byte-wide memory-backed controller.
module tb_x_sram_arb;
  import x_sram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        p0_valid, p0_rd, p1_valid, p1_rd;
  logic [15:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        mem_accept, mem_ready;
  logic [7:0]  mem_rdata;

  logic        o_p0_accept, o_p0_ready, o_p1_accept, o_p1_ready;
  logic [7:0]  o_p0_rdata, o_p1_rdata;
  logic        o_mem_advance, o_mem_valid, o_mem_rd_n_wr;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic [1:0]  o_dbg_state;

  x_sram_arb #(.DIV(4)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_p0_valid(p0_valid), .o_p0_accept(o_p0_accept), .i_p0_rd_n_wr(p0_rd),
    .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .o_p0_ready(o_p0_ready), .o_p0_rdata(o_p0_rdata),
    .i_p1_valid(p1_valid), .o_p1_accept(o_p1_accept), .i_p1_rd_n_wr(p1_rd),
    .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .o_p1_ready(o_p1_ready), .o_p1_rdata(o_p1_rdata),
    .o_mem_advance(o_mem_advance), .o_mem_valid(o_mem_valid), .i_mem_accept(mem_accept),
    .o_mem_rd_n_wr(o_mem_rd_n_wr), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .o_dbg_state(o_dbg_state)
  );

  // Extra instances only for the tick divider at DIV=3 and DIV=1.
  logic [1:0]  d3_acc, d3_rdy, d1_acc, d1_rdy, d3_st, d1_st;
  logic [7:0]  d3_rd0, d3_rd1, d3_wd, d1_rd0, d1_rd1, d1_wd;
  logic [15:0] d3_addr, d1_addr;
  logic        d3_adv, d3_valid, d3_rnw, d1_adv, d1_valid, d1_rnw;

  x_sram_arb #(.DIV(3)) u_div3 (
    .i_clk(clk), .i_rst(rst),
    .i_p0_valid(p0_valid), .o_p0_accept(d3_acc[0]), .i_p0_rd_n_wr(p0_rd),
    .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .o_p0_ready(d3_rdy[0]), .o_p0_rdata(d3_rd0),
    .i_p1_valid(p1_valid), .o_p1_accept(d3_acc[1]), .i_p1_rd_n_wr(p1_rd),
    .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .o_p1_ready(d3_rdy[1]), .o_p1_rdata(d3_rd1),
    .o_mem_advance(d3_adv), .o_mem_valid(d3_valid), .i_mem_accept(mem_accept),
    .o_mem_rd_n_wr(d3_rnw), .o_mem_addr(d3_addr), .o_mem_wdata(d3_wd),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .o_dbg_state(d3_st)
  );

  x_sram_arb #(.DIV(1)) u_div1 (
    .i_clk(clk), .i_rst(rst),
    .i_p0_valid(p0_valid), .o_p0_accept(d1_acc[0]), .i_p0_rd_n_wr(p0_rd),
    .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .o_p0_ready(d1_rdy[0]), .o_p0_rdata(d1_rd0),
    .i_p1_valid(p1_valid), .o_p1_accept(d1_acc[1]), .i_p1_rd_n_wr(p1_rd),
    .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .o_p1_ready(d1_rdy[1]), .o_p1_rdata(d1_rd1),
    .o_mem_advance(d1_adv), .o_mem_valid(d1_valid), .i_mem_accept(mem_accept),
    .o_mem_rd_n_wr(d1_rnw), .o_mem_addr(d1_addr), .o_mem_wdata(d1_wd),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .o_dbg_state(d1_st)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];
  logic [7:0] mem [0:65535];

  int acc0_cnt = 0, acc1_cnt = 0, rdy0_cnt = 0, rdy1_cnt = 0, p1_leak_cnt = 0;
  always @(posedge clk) begin
    if (o_p0_accept) acc0_cnt <= acc0_cnt + 1;
    if (o_p1_accept) acc1_cnt <= acc1_cnt + 1;
    if (o_p0_ready)  rdy0_cnt <= rdy0_cnt + 1;
    if (o_p1_ready)  rdy1_cnt <= rdy1_cnt + 1;
    if (o_p1_accept || o_p1_ready || (o_p1_rdata != 8'd0)) p1_leak_cnt <= p1_leak_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    p0_valid = 1'b0; p0_rd = 1'b0; p0_addr = 16'd0; p0_wdata = 8'd0;
    p1_valid = 1'b0; p1_rd = 1'b0; p1_addr = 16'd0; p1_wdata = 8'd0;
    mem_accept = 1'b0; mem_ready = 1'b0; mem_rdata = 8'd0;
  endtask

  // Returns at a negedge with reset just released.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_outputs", {o_p0_accept, o_p0_ready, o_p0_rdata, o_p1_accept, o_p1_ready, o_p1_rdata,
                        o_mem_valid, o_mem_rd_n_wr, o_mem_addr, o_mem_wdata}, 0);
    chk("rst_state", o_dbg_state, ST_IDLE);
    chk("rst_adv", {o_mem_advance, d3_adv, d1_adv}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_mem_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); #1;
      if (o_mem_valid) got = 1'b1;
    end
    chk("grant_seen", got, 1);
  endtask

  // Acts as the controller for one transaction expected to be owned by exp_who.
  task automatic serve(input int exp_who, input bit keep);
    bit got;
    logic rd;
    logic [15:0] a;
    logic [15:0] ea;
    ea = (exp_who == 1) ? p1_addr : p0_addr;
    wait_mem_valid(got);
    if (got) begin
      chk("mem_addr", o_mem_addr, ea);
      chk("mem_rd_n_wr", o_mem_rd_n_wr, (exp_who == 1) ? p1_rd : p0_rd);
      rd = o_mem_rd_n_wr;
      a  = o_mem_addr;
      if (!rd) begin
        chk("mem_wdata", o_mem_wdata, (exp_who == 1) ? p1_wdata : p0_wdata);
        mem[a] = o_mem_wdata;
      end
      mem_accept = 1'b1; #1;
      chk("accept_owner", (exp_who == 1) ? o_p1_accept : o_p0_accept, 1);
      chk("accept_other", (exp_who == 1) ? o_p0_accept : o_p1_accept, 0);
      @(negedge clk);
      mem_accept = 1'b0;
      if (!keep) begin
        if (exp_who == 1) p1_valid = 1'b0; else p0_valid = 1'b0;
      end
      if (rd) begin
        #1;
        chk("wait_no_valid", o_mem_valid, 0);
        chk("state_wait", o_dbg_state, ST_WAIT_RD);
        mem_ready = 1'b1; mem_rdata = mem[a]; #1;
        chk("ready_owner", (exp_who == 1) ? o_p1_ready : o_p0_ready, 1);
        chk("rdata_owner", (exp_who == 1) ? o_p1_rdata : o_p0_rdata, mem[ea]);
        chk("ready_other", (exp_who == 1) ? o_p0_ready : o_p1_ready, 0);
        chk("rdata_other", (exp_who == 1) ? o_p0_rdata : o_p1_rdata, 8'h00);
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 8'd0;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a0, r0, l1, r0_before;
    bit got;
    logic [0:0] exp_who;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0123] = 8'hA5;
    mem[16'h0020] = 8'h5A;

    // Tick divider after reset release.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("tick_div4", o_mem_advance, (c % 4) == 3);
      chk("tick_div3", d3_adv, (c % 3) == 2);
      chk("tick_div1", d1_adv, 1);
    end
    chk("idle_quiet_aux", {d3_acc, d3_rdy, d3_rd0, d3_rd1, d3_wd, d3_addr, d3_valid, d3_rnw, d3_st,
                           d1_acc, d1_rdy, d1_rd0, d1_rd1, d1_wd, d1_addr, d1_valid, d1_rnw, d1_st}, 0);

    // Single read from port 0.
    do_reset();
    a0 = acc0_cnt; r0 = rdy0_cnt; l1 = p1_leak_cnt;
    p0_valid = 1'b1; p0_rd = 1'b1; p0_addr = 16'h0123;
    serve(0, 0);
    @(negedge clk);
    chk("single_acc_pulses", acc0_cnt - a0, 1);
    chk("single_rdy_pulses", rdy0_cnt - r0, 1);
    chk("single_p1_quiet", p1_leak_cnt - l1, 0);

    // Contention straight after reset: p0 write wins, then p1 read.
    do_reset();
    p0_valid = 1'b1; p0_rd = 1'b0; p0_addr = 16'h0010; p0_wdata = 8'h3C;
    p1_valid = 1'b1; p1_rd = 1'b1; p1_addr = 16'h0020;
    serve(0, 0);
    chk("contend_p1_not_yet", acc1_cnt, 0);
    serve(1, 0);
    chk("contend_mem_0010", mem[16'h0010], 8'h3C);
    chk("contend_p1_acc", acc1_cnt, 1);

    // Fairness: both ports hold valid for eight writes.
    do_reset();
    p0_valid = 1'b1; p0_rd = 1'b0; p0_addr = 16'h1000; p0_wdata = 8'h11;
    p1_valid = 1'b1; p1_rd = 1'b0; p1_addr = 16'h2000; p1_wdata = 8'h22;
    for (int i = 0; i < 8; i++) exp_q.push_back(1'(i % 2));
    while (exp_q.size() > 0) begin
      exp_who = exp_q.pop_front();
      serve(int'(exp_who), 1);
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    chk("fair_mem_1000", mem[16'h1000], 8'h11);
    chk("fair_mem_2000", mem[16'h2000], 8'h22);

    // Reset while port 0 waits for read data.
    p0_valid = 1'b1; p0_rd = 1'b1; p0_addr = 16'h0123;
    r0_before = rdy0_cnt;
    wait_mem_valid(got);
    mem_accept = 1'b1;
    @(negedge clk);
    mem_accept = 1'b0; #1;
    chk("rstrd_in_wait", o_dbg_state, ST_WAIT_RD);
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 8'hEE; #1;
    chk("rstrd_no_ready", {o_p0_ready, o_p1_ready}, 2'b00);
    @(negedge clk); #1;
    chk("rstrd_state_idle", o_dbg_state, ST_IDLE);
    rst = 1'b0; mem_ready = 1'b0; mem_rdata = 8'd0; p0_valid = 1'b0;
    @(negedge clk);
    chk("rstrd_no_ready_pulse", rdy0_cnt - r0_before, 0);

    // New p1 read after the abandoned one; p0 must stay gated.
    p1_valid = 1'b1; p1_rd = 1'b1; p1_addr = 16'h0020;
    serve(1, 0);
    chk("rstrd_p1_ready_cnt", rdy1_cnt, 2);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
